// File: rtl/lcd_pkg.sv
// lcd_pkg: LCD character-buffer geometry, blank character and arbiter state encoding
package lcd_pkg;
   localparam int LCD_LOC_W = 5;
   localparam int LCD_DATA_W = 8;
   localparam int LCD_DEPTH = 32;
   localparam logic [7:0] CHAR_BLANK = 8'h20;
   typedef enum logic {IDLE, FILL} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from the slot after ptr
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   localparam int PTR_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               valid
);
   always_comb begin
      grant = '0;
      for (int k = NUM_REQ; k >= 1; k--)
         grant = eligible[(int'(ptr) + k) % NUM_REQ] ? NUM_REQ'(1) << ((int'(ptr) + k) % NUM_REQ) : grant;
   end
   assign valid = |eligible;
endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: shares the LCD buffer write port among requesters and a fill sequencer
module lcd_write_arbiter
   import lcd_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int LOC_W = LCD_LOC_W,
   parameter int DATA_W = LCD_DATA_W,
   parameter int DEPTH = LCD_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*LOC_W-1:0]  req_loc,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   input  logic                      fill_start,
   input  logic [DATA_W-1:0]         fill_char,
   output logic                      busy,
   output logic                      fill_done,
   output logic                      lcd_we,
   output logic [LOC_W-1:0]          lcd_loc,
   output logic [DATA_W-1:0]         lcd_data
);
   localparam int PTR_W = $clog2(NUM_REQ);
   arb_state_t state;
   logic [PTR_W-1:0] rr_ptr, gidx;
   logic [LOC_W-1:0] cnt, g_loc;
   logic [DATA_W-1:0] fill_q, g_data;
   logic [NUM_REQ-1:0] grant;
   logic valid, loc_ok;
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .eligible(req & ~ack),
      .ptr(rr_ptr),
      .grant(grant),
      .valid(valid)
   );
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         gidx = grant[i] ? PTR_W'(i) : gidx;
   end
   assign g_loc = req_loc[gidx*LOC_W +: LOC_W];
   assign g_data = req_data[gidx*DATA_W +: DATA_W];
   assign loc_ok = int'(g_loc) < DEPTH;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rr_ptr <= '0;
         cnt <= '0;
         fill_q <= '0;
         ack <= '0;
         busy <= 1'b0;
         fill_done <= 1'b0;
         lcd_we <= 1'b0;
         lcd_loc <= '0;
         lcd_data <= '0;
      end else begin
         ack <= '0;
         fill_done <= 1'b0;
         if (state == FILL) begin
            lcd_we <= 1'b1;
            lcd_loc <= cnt;
            lcd_data <= fill_q;
            cnt <= cnt + 1'b1;
            if (cnt == LOC_W'(DEPTH - 1)) begin
               fill_done <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end
         end else if (fill_start) begin
            fill_q <= fill_char;
            cnt <= '0;
            busy <= 1'b1;
            lcd_we <= 1'b0;
            state <= FILL;
         end else if (valid) begin
            ack <= grant;
            rr_ptr <= gidx;
            lcd_we <= loc_ok;
            // out-of-range locations are acknowledged but never reach the buffer
            if (loc_ok) begin
               lcd_loc <= g_loc;
               lcd_data <= g_data;
            end
         end else begin
            lcd_we <= 1'b0;
         end
      end
   end
endmodule
